// File: rtl/scan_mux.sv
// -----------------------------------------------------------------------------
// scan_mux
//
// Parametrised, registered N-channel multiplexer with an auto-scan mode.
// In manual mode the channel is chosen by `sel`. In scan mode an internal
// dwell counter holds each channel for DWELL enabled cycles and then steps
// to the next one, wrapping from CH-1 back to 0. The output is one cycle
// behind the inputs. No combinational path exists from inputs to outputs.
//
// Parameters
//   CH     number of input channels (2..64, need not be a power of 2)
//   DW     data width of one channel
//   SEL_W  width of the channel-index fields
//   DWELL  enabled cycles spent on each channel while scanning (>= 1)
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   en       in   clock enable; when low all state holds and f_valid drops
//   mode     in   0 = manual select, 1 = auto-scan
//   sel      in   manual channel index (ignored while mode = 1)
//   w        in   packed channel data, channel k at w[k*DW +: DW]
//   f        out  registered data of the selected channel
//   cur_sel  out  index of the channel currently presented on f
//   f_valid  out  f holds freshly sampled data from a legal channel
//   wrap     out  one-cycle pulse when a scan step goes from CH-1 to 0
// -----------------------------------------------------------------------------
module scan_mux #(
    parameter int CH    = 16,
    parameter int DW    = 1,
    parameter int SEL_W = $clog2(CH),
    parameter int DWELL = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic [CH*DW-1:0]     w,
    output logic [DW-1:0]        f,
    output logic [SEL_W-1:0]     cur_sel,
    output logic                 f_valid,
    output logic                 wrap
);

    // Dwell counter only has to reach DWELL-1; keep at least one bit.
    localparam int                DC_W      = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DC_W-1:0]   LAST_DCNT = DC_W'(DWELL - 1);
    localparam logic [SEL_W-1:0]  LAST_SEL  = SEL_W'(CH - 1);
    // One extra bit so CH itself is representable even when CH = 2**SEL_W.
    localparam logic [SEL_W:0]    CH_L      = (SEL_W + 1)'(CH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    state_t             state_r;
    logic [DC_W-1:0]    dcnt_r;
    logic [SEL_W-1:0]   cur_sel_r;
    logic [DW-1:0]      f_r;
    logic               f_valid_r;
    logic               wrap_r;

    logic [DC_W-1:0]    dwell_s;
    logic [SEL_W-1:0]   scan_base_s;
    logic [SEL_W-1:0]   nsel_s;
    logic [DC_W-1:0]    ndcnt_s;
    logic               nsel_legal_s;
    logic               step_wrap_s;
    logic [DW-1:0]      ndata_s;

    // True when idx names an existing channel (only matters for non-power-of-2 CH).
    function automatic logic legal_sel(input logic [SEL_W-1:0] idx);
        return ({1'b0, idx} < CH_L);
    endfunction

    // Returns channel idx from the packed bus; zero for an index with no channel.
    function automatic logic [DW-1:0] pick_channel(
        input logic [CH*DW-1:0] data,
        input logic [SEL_W-1:0] idx
    );
        logic [DW-1:0] res;
        res = '0;
        for (int k = 0; k < CH; k++) begin
            res = ({1'b0, idx} == (SEL_W + 1)'(k)) ? data[k*DW +: DW] : res;
        end
        return res;
    endfunction

    // Next-select, next dwell count and wrap decision for the coming enabled edge.
    always_comb begin
        // The dwell count is only meaningful while already scanning; entering
        // scan from IDLE or MANUAL always starts a fresh dwell at count 0.
        dwell_s      = (state_r == ST_SCAN) ? dcnt_r : '0;
        // A manual out-of-range index left in cur_sel must not leak into scan.
        scan_base_s  = legal_sel(cur_sel_r) ? cur_sel_r : '0;
        nsel_s       = sel;
        ndcnt_s      = '0;
        step_wrap_s  = 1'b0;
        if (mode) begin
            if (dwell_s != LAST_DCNT) begin
                nsel_s  = scan_base_s;
                ndcnt_s = dwell_s + DC_W'(1);
            end else begin
                nsel_s      = (scan_base_s == LAST_SEL) ? '0 : scan_base_s + SEL_W'(1);
                ndcnt_s     = '0;
                step_wrap_s = (scan_base_s == LAST_SEL);
            end
        end else begin
            nsel_s  = sel;
            ndcnt_s = '0;
        end
        nsel_legal_s = legal_sel(nsel_s);
        ndata_s      = nsel_legal_s ? pick_channel(w, nsel_s) : '0;
    end

    // Mode FSM with registered data, index, valid and wrap outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            dcnt_r    <= '0;
            cur_sel_r <= '0;
            f_r       <= '0;
            f_valid_r <= 1'b0;
            wrap_r    <= 1'b0;
        end else if (en) begin
            case (state_r)
                ST_IDLE, ST_MANUAL, ST_SCAN: state_r <= mode ? ST_SCAN : ST_MANUAL;
                default:                     state_r <= ST_IDLE;
            endcase
            dcnt_r    <= ndcnt_s;
            cur_sel_r <= nsel_s;
            f_r       <= ndata_s;
            f_valid_r <= nsel_legal_s;
            wrap_r    <= step_wrap_s;
        end else begin
            // Disabled edge: everything holds except the freshness flags.
            f_valid_r <= 1'b0;
            wrap_r    <= 1'b0;
        end
    end

    assign f       = f_r;
    assign cur_sel = cur_sel_r;
    assign f_valid = f_valid_r;
    assign wrap    = wrap_r;

endmodule

// File: tb/tb_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_scan_mux
//
// Directed testbench for scan_mux. Three instances cover the configurations
// of interest:
//   A: CH=16, DW=1, DWELL=4  (manual selection)
//   B: CH=4,  DW=8, DWELL=2  (scan sequence, enable hold, mode switching)
//   C: CH=10, DW=4, DWELL=1  (out-of-range select, single-cycle dwell, async reset)
// Each output group is compared as {f, cur_sel, f_valid, wrap}.
// -----------------------------------------------------------------------------
module tb_scan_mux;

    logic clk = 1'b0;
    logic rst_n;

    // Instance A
    logic        en_a, mode_a;
    logic [3:0]  sel_a;
    logic [15:0] w_a;
    logic        f_a;
    logic [3:0]  cur_a;
    logic        v_a, wr_a;

    // Instance B
    logic        en_b, mode_b;
    logic [1:0]  sel_b;
    logic [31:0] w_b;
    logic [7:0]  f_b;
    logic [1:0]  cur_b;
    logic        v_b, wr_b;

    // Instance C
    logic        en_c, mode_c;
    logic [3:0]  sel_c;
    logic [39:0] w_c;
    logic [3:0]  f_c;
    logic [3:0]  cur_c;
    logic        v_c, wr_c;

    int checks = 0;
    int errors = 0;

    // 10 time-unit clock
    always #5 clk = ~clk;

    scan_mux #(.CH(16), .DW(1), .DWELL(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .mode(mode_a), .sel(sel_a), .w(w_a),
        .f(f_a), .cur_sel(cur_a), .f_valid(v_a), .wrap(wr_a)
    );

    scan_mux #(.CH(4), .DW(8), .DWELL(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .mode(mode_b), .sel(sel_b), .w(w_b),
        .f(f_b), .cur_sel(cur_b), .f_valid(v_b), .wrap(wr_b)
    );

    scan_mux #(.CH(10), .DW(4), .DWELL(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en_c), .mode(mode_c), .sel(sel_c), .w(w_c),
        .f(f_c), .cur_sel(cur_c), .f_valid(v_c), .wrap(wr_c)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en_a = 1'b0; mode_a = 1'b0; sel_a = 4'd5; w_a = '1;
        en_b = 1'b0; mode_b = 1'b1; sel_b = 2'd0; w_b = '1;
        en_c = 1'b0; mode_c = 1'b0; sel_c = 4'd0; w_c = '1;
        #12;
        checks++;
        if ({f_a, cur_a, v_a, wr_a} !== 7'd0) begin
            errors++;
            $display("FAIL reset_a: got %h expected %h", {f_a, cur_a, v_a, wr_a}, 7'd0);
        end
        checks++;
        if ({f_b, cur_b, v_b, wr_b} !== 12'd0) begin
            errors++;
            $display("FAIL reset_b: got %h expected %h", {f_b, cur_b, v_b, wr_b}, 12'd0);
        end
        checks++;
        if ({f_c, cur_c, v_c, wr_c} !== 10'd0) begin
            errors++;
            $display("FAIL reset_c: got %h expected %h", {f_c, cur_c, v_c, wr_c}, 10'd0);
        end
        // Release with en low: nothing may move over five edges.
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({f_a, cur_a, v_a, wr_a} !== 7'd0) begin
                errors++;
                $display("FAIL reset_hold edge %0d: got %h expected %h", i, {f_a, cur_a, v_a, wr_a}, 7'd0);
            end
        end
    endtask

    task automatic test_manual();
        logic [3:0] sels [3];
        logic       fexp [3];
        logic [6:0] exp_v;
        sels = '{4'd15, 4'd2, 4'd0};
        fexp = '{1'b1, 1'b1, 1'b0};
        w_a    = 16'h8004;
        mode_a = 1'b0;
        en_a   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sel_a = sels[i];
            tick();
            exp_v = {fexp[i], sels[i], 1'b1, 1'b0};
            checks++;
            if ({f_a, cur_a, v_a, wr_a} !== exp_v) begin
                errors++;
                $display("FAIL manual sel=%0d: got %h expected %h", sels[i], {f_a, cur_a, v_a, wr_a}, exp_v);
            end
        end
        en_a = 1'b0;
    endtask

    task automatic test_scan();
        logic [7:0]  fexp [8];
        logic [1:0]  cexp [8];
        logic        wexp;
        logic [11:0] exp_v;
        fexp = '{8'hAA, 8'hBB, 8'hBB, 8'hCC, 8'hCC, 8'hDD, 8'hDD, 8'hAA};
        cexp = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        w_b    = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        mode_b = 1'b1;
        en_b   = 1'b1;
        // First edge leaves IDLE and is dwell cycle 0 on channel 0.
        for (int i = 0; i < 8; i++) begin
            tick();
            wexp  = (i == 7) ? 1'b1 : 1'b0;
            exp_v = {fexp[i], cexp[i], 1'b1, wexp};
            checks++;
            if ({f_b, cur_b, v_b, wr_b} !== exp_v) begin
                errors++;
                $display("FAIL scan edge %0d: got %h expected %h", i, {f_b, cur_b, v_b, wr_b}, exp_v);
            end
        end
    endtask

    task automatic test_en_hold();
        logic [11:0] exp_v;
        // From channel 0 at count 0: ch0, ch1, ch1, ch2 (just arrived, count 0).
        repeat (4) tick();
        exp_v = {8'hCC, 2'd2, 1'b1, 1'b0};
        checks++;
        if ({f_b, cur_b, v_b, wr_b} !== exp_v) begin
            errors++;
            $display("FAIL en_pre: got %h expected %h", {f_b, cur_b, v_b, wr_b}, exp_v);
        end
        en_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_v = {8'hCC, 2'd2, 1'b0, 1'b0};
            checks++;
            if ({f_b, cur_b, v_b, wr_b} !== exp_v) begin
                errors++;
                $display("FAIL en_hold edge %0d: got %h expected %h", i, {f_b, cur_b, v_b, wr_b}, exp_v);
            end
        end
        // Frozen count resumes: one more cycle on channel 2, then channel 3.
        en_b = 1'b1;
        tick();
        exp_v = {8'hCC, 2'd2, 1'b1, 1'b0};
        checks++;
        if ({f_b, cur_b, v_b, wr_b} !== exp_v) begin
            errors++;
            $display("FAIL en_resume_a: got %h expected %h", {f_b, cur_b, v_b, wr_b}, exp_v);
        end
        tick();
        exp_v = {8'hDD, 2'd3, 1'b1, 1'b0};
        checks++;
        if ({f_b, cur_b, v_b, wr_b} !== exp_v) begin
            errors++;
            $display("FAIL en_resume_b: got %h expected %h", {f_b, cur_b, v_b, wr_b}, exp_v);
        end
    endtask

    task automatic test_mode_switch();
        logic [11:0] exp_v;
        mode_b = 1'b0;
        sel_b  = 2'd1;
        tick();
        exp_v = {8'hBB, 2'd1, 1'b1, 1'b0};
        checks++;
        if ({f_b, cur_b, v_b, wr_b} !== exp_v) begin
            errors++;
            $display("FAIL to_manual: got %h expected %h", {f_b, cur_b, v_b, wr_b}, exp_v);
        end
        // Back to scan: channel 1 gets a full two-cycle dwell.
        mode_b = 1'b1;
        sel_b  = 2'd3;
        tick();
        checks++;
        if ({f_b, cur_b, v_b, wr_b} !== exp_v) begin
            errors++;
            $display("FAIL to_scan_dwell: got %h expected %h", {f_b, cur_b, v_b, wr_b}, exp_v);
        end
        tick();
        exp_v = {8'hCC, 2'd2, 1'b1, 1'b0};
        checks++;
        if ({f_b, cur_b, v_b, wr_b} !== exp_v) begin
            errors++;
            $display("FAIL to_scan_step: got %h expected %h", {f_b, cur_b, v_b, wr_b}, exp_v);
        end
        en_b = 1'b0;
    endtask

    task automatic test_out_of_range();
        logic [3:0] fexp [4];
        logic [3:0] cexp [4];
        logic       vexp [4];
        logic       wexp [4];
        logic [9:0] exp_v;
        // Channel k carries value k+1.
        for (int k = 0; k < 10; k++) begin
            w_c[k*4 +: 4] = 4'(k + 1);
        end
        fexp = '{4'h0, 4'hA, 4'h1, 4'h2};
        cexp = '{4'd12, 4'd9, 4'd0, 4'd1};
        vexp = '{1'b0, 1'b1, 1'b1, 1'b1};
        wexp = '{1'b0, 1'b0, 1'b1, 1'b0};
        en_c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            // Steps 0,1 manual (sel 12 then 9); steps 2,3 scan with DWELL=1.
            mode_c = (i >= 2) ? 1'b1 : 1'b0;
            sel_c  = (i == 0) ? 4'd12 : 4'd9;
            tick();
            exp_v = {fexp[i], cexp[i], vexp[i], wexp[i]};
            checks++;
            if ({f_c, cur_c, v_c, wr_c} !== exp_v) begin
                errors++;
                $display("FAIL range_scan step %0d: got %h expected %h", i, {f_c, cur_c, v_c, wr_c}, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [9:0] exp_v;
        // Assert reset between edges; outputs must clear before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({f_c, cur_c, v_c, wr_c} !== 10'd0) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", {f_c, cur_c, v_c, wr_c}, 10'd0);
        end
        #10;
        rst_n  = 1'b1;
        mode_c = 1'b0;
        sel_c  = 4'd3;
        tick();
        exp_v = {4'h4, 4'd3, 1'b1, 1'b0};
        checks++;
        if ({f_c, cur_c, v_c, wr_c} !== exp_v) begin
            errors++;
            $display("FAIL post_reset: got %h expected %h", {f_c, cur_c, v_c, wr_c}, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_scan();
        test_en_hold();
        test_mode_switch();
        test_out_of_range();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
